zap_ram_arbiter: RTL
====================

Name: zap_ram_arbiter

Overview:
Shares one external single-ported RAM between the instruction-side and data-side memory stall-handshake units (zap_mem_shm outputs). It sits between those two units and the SoC RAM port. It grants one transaction at a time with round-robin fairness and forwards the RAM response to the owning requester. A watchdog terminates hung RAM transactions and reports a bus error.

Parameters:
TIMEOUT, 1024, max cycles a granted transaction may see i_ram_stall high before abort; 0 disables watchdog
TW, 11, watchdog counter width; must hold TIMEOUT

Ports:
i_clk  in  1  clock
i_reset_n  in  1  asynchronous active-low reset
i_iside_rd_en  in  1  I-side read request, held until done
i_iside_addr  in  32  I-side address
i_iside_flush  in  1  I-side abandons outstanding request
o_iside_data  out  32  I-side read data, registered
o_iside_stall  out  1  I-side stall; low for exactly one cycle = done
o_iside_err  out  1  I-side bus error, valid with done
i_dside_rd_en  in  1  D-side read request
i_dside_wr_en  in  1  D-side write request
i_dside_addr  in  32  D-side address
i_dside_data  in  32  D-side write data
i_dside_ben  in  4  D-side byte enables
o_dside_data  out  32  D-side read data, registered
o_dside_stall  out  1  D-side stall
o_dside_err  out  1  D-side bus error, valid with done
o_ram_addr  out  32  RAM address
o_ram_rd_en  out  1  RAM read command
o_ram_wr_en  out  1  RAM write command
o_ram_ben  out  4  RAM byte enables
o_ram_data  out  32  RAM write data
i_ram_data  in  32  RAM read data
i_ram_stall  in  1  RAM busy; low = command accepted and read data valid

Behaviour:
- Reset (async, i_reset_n=0): state IDLE, last_grant=I, all RAM outputs 0, data outputs 0, err 0, watchdog 0. Requester stall = (request active) combinationally, so stall goes high the first cycle a request appears.
- States: IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D.
- IDLE: both requesting → grant side opposite last_grant. Single requester → grant it. Request of D = rd_en|wr_en; rd_en&wr_en together is illegal; treat as write. I request with i_iside_flush high is ignored. Grant registers addr/ben/data/rd/wr onto o_ram_* next edge, sets last_grant, enters BUSY_x.
- BUSY_x: o_ram_* held constant. Watchdog increments each cycle i_ram_stall=1. On i_ram_stall=0: capture i_ram_data into o_x_data (reads only; writes leave data unchanged), clear o_ram_rd_en/wr_en, go DONE_x. Watchdog reaching TIMEOUT: drop RAM command, set o_x_err=1, go DONE_x.
- DONE_x: o_x_stall=0 for this one cycle; o_x_err valid. Next cycle → IDLE, err cleared. Requester must drop or change its request after done. Minimum latency: request cycle 0, RAM command cycle 1, done cycle 2 if i_ram_stall=0 in cycle 1.
- Other side's stall stays high throughout; no back-to-back grants without passing IDLE (1 idle cycle/transaction).
- Flush: i_iside_flush in BUSY_I does not abort RAM. The transaction completes, the data is discarded (o_iside_data unchanged), DONE_I is skipped, and the block returns to IDLE. Flush never affects the D side.
- Address and data are never modified; there is no alignment checking.
- Watchdog resets to 0 on every entry to BUSY_x.

Test Plan:
- Single D write addr=0x100, data=0xDEADBEEF, ben=0xF, RAM stall 0 → o_ram_wr_en high in cycle 1 with those values; o_dside_stall low in cycle 2 only.
- I read 0x8000 with RAM stall high 3 cycles, i_ram_data=0xE3A00001 → o_iside_data=0xE3A00001, o_iside_stall low in cycle 5.
- Both request continuously from reset → grants alternate D, I, D, I; each side gets 1 of every 2 transactions.
- I granted, i_iside_flush pulsed mid-BUSY_I, RAM returns 0x1234 → o_iside_data unchanged, no done pulse, then D is serviced.
- TIMEOUT=8, RAM stall held high → after 8 stall cycles the RAM command drops and the D-side done carries o_dside_err=1; the next transaction has err=0.
- Assert i_reset_n low mid-BUSY_D → all o_ram_* go 0 immediately (async); state IDLE after release.

Source files
------------

// File: rtl/zap_ram_arbiter.sv
// zap_ram_arbiter: round-robin share of one single-ported RAM between the
// I-side and D-side stall-handshake units, with a stall watchdog.
module zap_ram_arbiter #(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned TW      = 11
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_iside_rd_en,
  input  logic [31:0] i_iside_addr,
  input  logic        i_iside_flush,
  output logic [31:0] o_iside_data,
  output logic        o_iside_stall,
  output logic        o_iside_err,
  input  logic        i_dside_rd_en,
  input  logic        i_dside_wr_en,
  input  logic [31:0] i_dside_addr,
  input  logic [31:0] i_dside_data,
  input  logic [3:0]  i_dside_ben,
  output logic [31:0] o_dside_data,
  output logic        o_dside_stall,
  output logic        o_dside_err,
  output logic [31:0] o_ram_addr,
  output logic        o_ram_rd_en,
  output logic        o_ram_wr_en,
  output logic [3:0]  o_ram_ben,
  output logic [31:0] o_ram_data,
  input  logic [31:0] i_ram_data,
  input  logic        i_ram_stall
);

  typedef enum logic [2:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    DONE_I,
    DONE_D
  } state_t;

  localparam int unsigned WD_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  state_t        state;
  state_t        state_nxt;
  logic          last_d;
  logic          flushed;
  logic [TW-1:0] wd_cnt;

  logic req_i;
  logic req_d;
  logic grant_i;
  logic grant_d;
  logic wd_hit;
  logic ram_done;
  logic flush_any;

  assign req_i     = i_iside_rd_en & ~i_iside_flush;
  assign req_d     = i_dside_rd_en | i_dside_wr_en;
  assign grant_d   = req_d & (~req_i | ~last_d);
  assign grant_i   = req_i & ~grant_d;
  assign ram_done  = ~i_ram_stall;
  assign flush_any = flushed | i_iside_flush;
  assign wd_hit    = (TIMEOUT != 0) && i_ram_stall &&
                     (wd_cnt == TW'(WD_LAST));

  assign o_iside_stall = i_iside_rd_en & (state != DONE_I);
  assign o_dside_stall = req_d & (state != DONE_D);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (grant_d)      state_nxt = BUSY_D;
        else if (grant_i) state_nxt = BUSY_I;
      end
      BUSY_I: begin
        // a flushed fetch finishes on the bus but never reports done
        if (ram_done || wd_hit)
          state_nxt = flush_any ? IDLE : DONE_I;
      end
      BUSY_D: begin
        if (ram_done || wd_hit) state_nxt = DONE_D;
      end
      DONE_I:  state_nxt = IDLE;
      DONE_D:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      last_d       <= 1'b0;
      flushed      <= 1'b0;
      wd_cnt       <= '0;
      o_ram_addr   <= '0;
      o_ram_rd_en  <= 1'b0;
      o_ram_wr_en  <= 1'b0;
      o_ram_ben    <= '0;
      o_ram_data   <= '0;
      o_iside_data <= '0;
      o_dside_data <= '0;
      o_iside_err  <= 1'b0;
      o_dside_err  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          wd_cnt      <= '0;
          flushed     <= 1'b0;
          o_iside_err <= 1'b0;
          o_dside_err <= 1'b0;
          if (grant_d) begin
            last_d      <= 1'b1;
            o_ram_addr  <= i_dside_addr;
            o_ram_data  <= i_dside_data;
            o_ram_ben   <= i_dside_ben;
            o_ram_wr_en <= i_dside_wr_en;
            o_ram_rd_en <= i_dside_rd_en & ~i_dside_wr_en;
          end else if (grant_i) begin
            last_d      <= 1'b0;
            o_ram_addr  <= i_iside_addr;
            o_ram_data  <= '0;
            o_ram_ben   <= 4'hF;
            o_ram_wr_en <= 1'b0;
            o_ram_rd_en <= 1'b1;
          end
        end
        BUSY_I, BUSY_D: begin
          if (state == BUSY_I && i_iside_flush) flushed <= 1'b1;
          if (ram_done) begin
            o_ram_rd_en <= 1'b0;
            o_ram_wr_en <= 1'b0;
            if (o_ram_rd_en) begin
              if (state == BUSY_D)  o_dside_data <= i_ram_data;
              else if (!flush_any) o_iside_data <= i_ram_data;
            end
          end else if (wd_hit) begin
            o_ram_rd_en <= 1'b0;
            o_ram_wr_en <= 1'b0;
            if (state == BUSY_D) o_dside_err <= 1'b1;
            else                 o_iside_err <= ~flush_any;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: begin
          o_iside_err <= 1'b0;
          o_dside_err <= 1'b0;
        end
      endcase
    end
  end

endmodule
